// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence controller.
//   state_e     : controller FSM states
//   LfsrReseed  : LFSR value used at reset and in place of a lock-up seed
//   LfsrTap*    : feedback tap positions of the 10-bit LFSR
//   lfsr_next() : one LFSR step, next = {r[8:0], r[4]^r[7]^r[3]}
package simon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StShowOn,
    StShowOff,
    StWaitIn,
    StWin,
    StFail
  } state_e;

  localparam logic [9:0] LfsrReseed = 10'h2A5;

  localparam int unsigned LfsrTapA = 4;
  localparam int unsigned LfsrTapB = 7;
  localparam int unsigned LfsrTapC = 3;

  function automatic logic [9:0] lfsr_next(input logic [9:0] r);
    return {r[8:0], r[LfsrTapA] ^ r[LfsrTapB] ^ r[LfsrTapC]};
  endfunction

endpackage

// File: rtl/simon_lfsr10.sv
// 10-bit shift-left LFSR that supplies the colour sequence.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, state returns to LfsrReseed
//   load_i  : load seed_i (all-zero / all-one seeds replaced by LfsrReseed)
//   seed_i  : seed value
//   step_i  : advance one step (load_i has priority)
//   state_o : current LFSR state
module simon_lfsr10 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [9:0] seed_i,
  input  logic       step_i,
  output logic [9:0] state_o
);
  import simon_pkg::*;

  logic [9:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      // 0x000 and 0x3FF would leave the sequence stuck on one colour.
      state_d = (seed_i == 10'h000 || seed_i == 10'h3FF) ? LfsrReseed : seed_i;
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LfsrReseed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game sequence controller: grows a random colour sequence one step per
// round, displays it with on/off phases, then checks the player's presses.
//   clk, resetn            : clock, asynchronous active-low reset
//   seed, start            : LFSR seed, sampled when a start pulse is accepted
//   btn_valid, btn         : player press strobe and colour
//   show_valid, show_color : colour currently displayed (colour 0 when idle)
//   busy                   : a game round is in progress
//   level                  : current sequence length
//   win, fail              : held in the WIN / FAIL end states
// Optional build macro SIMON_TIMEOUT_EN adds parameter TIMEOUT_CYC: sitting in
// WAIT_IN for TIMEOUT_CYC cycles without a press ends the game in FAIL.
module simon_seq_ctrl #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned STEP_CYC = 4
`ifdef SIMON_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] seed,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn,
  output logic       show_valid,
  output logic [1:0] show_color,
  output logic       busy,
  output logic [4:0] level,
  output logic       win,
  output logic       fail
);
  import simon_pkg::*;

  localparam int unsigned AddrW = $clog2(MAX_LEN);
  localparam int unsigned TmrW  = $clog2(STEP_CYC + 1);

  state_e          state_q;
  logic [4:0]      level_q, idx_q;
  logic [TmrW-1:0] tmr_q;
  logic            show_valid_q, busy_q, win_q, fail_q;
  logic [1:0]      show_color_q;
  logic [1:0]      mem_q [MAX_LEN];

  logic [9:0] lfsr_state, lfsr_nxt;
  logic [1:0] gen_color;
  logic [4:0] idx_nxt;
  logic       start_ok, tmr_done, last_idx, unused_lfsr;

  assign start_ok  = start && (state_q == StIdle || state_q == StWin || state_q == StFail);
  assign lfsr_nxt  = lfsr_next(lfsr_state);
  assign gen_color = lfsr_nxt[9:8];
  assign unused_lfsr = ^lfsr_nxt[7:0];
  assign idx_nxt   = idx_q + 5'd1;
  assign last_idx  = (idx_nxt == level_q);
  assign tmr_done  = (tmr_q == TmrW'(STEP_CYC - 1));

  simon_lfsr10 u_lfsr (
    .clk_i  (clk),
    .rst_ni (resetn),
    .load_i (start_ok),
    .seed_i (seed),
    .step_i (state_q == StGen),
    .state_o(lfsr_state)
  );

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
  logic [ToW-1:0] to_q;
  logic           to_done;
  assign to_done = (to_q == ToW'(TIMEOUT_CYC - 1));
`endif

  // Sequence memory: no reset, every entry is written in GEN before it is read.
  always_ff @(posedge clk) begin
    if (state_q == StGen) begin
      mem_q[level_q[AddrW-1:0]] <= gen_color;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      level_q      <= '0;
      idx_q        <= '0;
      tmr_q        <= '0;
      show_valid_q <= 1'b0;
      show_color_q <= '0;
      busy_q       <= 1'b0;
      win_q        <= 1'b0;
      fail_q       <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StWin, StFail: begin
          if (start_ok) begin
            state_q <= StGen;
            level_q <= '0;
            win_q   <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StGen: begin
          level_q      <= level_q + 5'd1;
          idx_q        <= '0;
          tmr_q        <= '0;
          state_q      <= StShowOn;
          show_valid_q <= 1'b1;
          // mem[0] is being written this very edge on the first round.
          show_color_q <= (level_q == 5'd0) ? gen_color : mem_q[0];
        end
        StShowOn: begin
          if (tmr_done) begin
            tmr_q        <= '0;
            state_q      <= StShowOff;
            show_valid_q <= 1'b0;
            show_color_q <= '0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StShowOff: begin
          if (tmr_done) begin
            tmr_q <= '0;
            if (!last_idx) begin
              idx_q        <= idx_nxt;
              state_q      <= StShowOn;
              show_valid_q <= 1'b1;
              show_color_q <= mem_q[idx_nxt[AddrW-1:0]];
            end else begin
              idx_q   <= '0;
              state_q <= StWaitIn;
`ifdef SIMON_TIMEOUT_EN
              to_q    <= '0;
`endif
            end
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StWaitIn: begin
          if (btn_valid) begin
`ifdef SIMON_TIMEOUT_EN
            to_q <= '0;
`endif
            if (btn != mem_q[idx_q[AddrW-1:0]]) begin
              state_q <= StFail;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (!last_idx) begin
              idx_q <= idx_nxt;
            end else if (level_q == 5'(MAX_LEN)) begin
              state_q <= StWin;
              win_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StGen;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (to_done) begin
            state_q <= StFail;
            fail_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            to_q <= to_q + ToW'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign show_valid = show_valid_q;
  assign show_color = show_color_q;
  assign busy       = busy_q;
  assign level      = level_q;
  assign win        = win_q;
  assign fail       = fail_q;

endmodule
